// File: rtl/ps2_keypad_rx_if.sv
// Output bundle of the PS/2 keypad receiver: held-key vector plus the raw
// byte/error strobes used for the debug display.
interface ps2_keypad_rx_if;
    logic [3:0] keyboard;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    modport master (output keyboard, output code, output code_valid, output frame_err);
    modport slave  (input  keyboard, input  code, input  code_valid, input  frame_err);
endinterface

// File: rtl/ps2_keypad_rx.sv
// PS/2 device-to-host frame receiver with make/break/E0 decoding into a
// level-held 4-bit game key vector (left, right, rotate, down).
module ps2_keypad_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic            FPGA_GlobalClock,
    input  logic            rst_n,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_keypad_rx_if.master keypad
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, RX} state_t;

    state_t        state, state_next;
    logic [1:0]    clk_sync, data_sync;
    logic          filt_clk, fall;
    logic [FW-1:0] filt_cnt;
    logic [3:0]    bitcnt;
    logic [8:0]    shift;
    logic [TW-1:0] timer;
    logic          good, bad, timeout;
    logic          key_hit;
    logic [1:0]    key_idx;
    logic          ext, brk;
    logic [3:0]    keyboard;
    logic [7:0]    code;
    logic          code_valid, frame_err;

    wire clk_s  = clk_sync[1];
    wire data_s = data_sync[1];

    // NOTE: reset is synchronous, so it is simply the first branch inside the
    // clocked process; all state uses <= so every register sees pre-edge values.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Level only moves after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                fall     <= ~clk_s;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge FPGA_GlobalClock) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        good       = 1'b0;
        bad        = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: if (fall && !data_s) state_next = RX;
            RX: begin
                if (fall) begin
                    if (bitcnt == 4'd9) begin
                        state_next = IDLE;
                        // shift holds data + parity; odd total and stop=1 is a good frame
                        if (data_s && (^shift)) good = 1'b1;
                        else                    bad  = 1'b1;
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge FPGA_GlobalClock) begin
        if (!rst_n) begin
            bitcnt <= '0;
            shift  <= '0;
            timer  <= '0;
        end else if (state == IDLE) begin
            bitcnt <= '0;
            timer  <= '0;
        end else if (fall) begin
            timer <= '0;
            if (bitcnt != 4'd9) begin
                shift  <= {data_s, shift[8:1]};
                bitcnt <= bitcnt + 1'b1;
            end
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        key_hit = 1'b0;
        key_idx = 2'd0;
        if (ext) begin
            case (shift[7:0])
                8'h6B: begin key_hit = 1'b1; key_idx = 2'd0; end
                8'h74: begin key_hit = 1'b1; key_idx = 2'd1; end
                8'h75: begin key_hit = 1'b1; key_idx = 2'd2; end
                8'h72: begin key_hit = 1'b1; key_idx = 2'd3; end
                default: ;
            endcase
        end else begin
            case (shift[7:0])
                8'h1C: begin key_hit = 1'b1; key_idx = 2'd0; end
                8'h23: begin key_hit = 1'b1; key_idx = 2'd1; end
                8'h1D: begin key_hit = 1'b1; key_idx = 2'd2; end
                8'h1B: begin key_hit = 1'b1; key_idx = 2'd3; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge FPGA_GlobalClock) begin
        if (!rst_n) begin
            keyboard   <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            code_valid <= good;
            frame_err  <= bad | timeout;
            if (good) begin
                code <= shift[7:0];
                case (shift[7:0])
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    default: begin
                        if (key_hit) keyboard[key_idx] <= ~brk;
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign keypad.keyboard   = keyboard;
    assign keypad.code       = code;
    assign keypad.code_valid = code_valid;
    assign keypad.frame_err  = frame_err;
endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Self-checking bench for ps2_keypad_rx: directed make/break, parity, timeout,
// glitch and reset scenarios, then random byte streams against a key model.
module tb_ps2_keypad_rx;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_keypad_rx_if kif ();

    ps2_keypad_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .FPGA_GlobalClock(clk),
        .rst_n           (rst_n),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .keypad          (kif.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (kif.code_valid) cv_cnt++;
        if (kif.frame_err) fe_cnt++;
        if (kif.code_valid && kif.frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: key state as a plain array of held flags.
    bit         m_held[4];
    bit         m_ext, m_brk;
    logic [7:0] m_code;

    function automatic logic [3:0] m_kb();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_held[i];
        return v;
    endfunction

    function automatic int key_of(bit ext, logic [7:0] b);
        if (ext) begin
            if (b == 8'h6B) return 0;
            if (b == 8'h74) return 1;
            if (b == 8'h75) return 2;
            if (b == 8'h72) return 3;
        end else begin
            if (b == 8'h1C) return 0;
            if (b == 8'h23) return 1;
            if (b == 8'h1D) return 2;
            if (b == 8'h1B) return 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_code = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        m_code = b;
        if (b == 8'hE0)      m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            k = key_of(m_ext, b);
            if (k >= 0) m_held[k] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device-to-host frame: start, 8 data LSB-first, odd parity, stop.
    // Optional clock glitch in the high phase of one bit, or a one-cycle
    // reset pulse in the low phase of one bit; nbits < 11 truncates the frame.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input int glitch_bit, input int rst_bit, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(8);
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                tick(FILTER_LEN - 2);
                ps2_clk = 1'b1;
                tick(10);
            end else begin
                tick(12);
            end
            ps2_clk = 1'b0;
            if (i == rst_bit) begin
                tick(3);
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
                tick(16);
            end else begin
                tick(20);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(30);
    endtask

    task automatic send_checked(input logic [7:0] b, input bit bad_par, input int glitch_bit);
        int cv0, fe0;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(b, bad_par, glitch_bit, -1, 11);
        if (!bad_par) model_byte(b);
        check($sformatf("code_valid count byte %02h", b), cv_cnt - cv0, bad_par ? 0 : 1);
        check($sformatf("frame_err count byte %02h", b), fe_cnt - fe0, bad_par ? 1 : 0);
        check($sformatf("keyboard after %02h", b), kif.keyboard, m_kb());
        check($sformatf("code after %02h", b), kif.code, m_code);
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] mapped[8];
        logic [7:0] other[3];
        int r;
        mapped = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C, 8'h23, 8'h1D, 8'h1B};
        other  = '{8'hE1, 8'hAA, 8'hFA};
        r = $urandom_range(0, 9);
        if (r <= 1) return 8'hE0;
        if (r == 2) return 8'hF0;
        if (r <= 6) return mapped[$urandom_range(0, 7)];
        if (r == 7) return other[$urandom_range(0, 2)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int cv0, fe0;
        model_reset();
        tick(4);
        rst_n = 1'b1;
        tick(2);
        check("reset keyboard", kif.keyboard, 4'h0);
        check("reset code", kif.code, 8'h00);
        check("reset code_valid", kif.code_valid, 1'b0);
        check("reset frame_err", kif.frame_err, 1'b0);

        // Left arrow make then break
        send_checked(8'hE0, 0, -1);
        send_checked(8'h6B, 0, -1);
        check("left make kb", kif.keyboard, 4'b0001);
        send_checked(8'hE0, 0, -1);
        send_checked(8'hF0, 0, -1);
        send_checked(8'h6B, 0, -1);
        check("left break kb", kif.keyboard, 4'b0000);

        // Simultaneous keys
        send_checked(8'h1D, 0, -1);
        send_checked(8'hE0, 0, -1);
        send_checked(8'h72, 0, -1);
        check("W+down kb", kif.keyboard, 4'b1100);
        send_checked(8'hF0, 0, -1);
        send_checked(8'h1D, 0, -1);
        check("W break kb", kif.keyboard, 4'b1000);
        send_checked(8'hE0, 0, -1);
        send_checked(8'hF0, 0, -1);
        send_checked(8'h72, 0, -1);

        // Parity error after E0: ext survives, so the retry decodes as an arrow
        send_checked(8'hE0, 0, -1);
        send_checked(8'h6B, 1, -1);
        send_checked(8'h6B, 0, -1);
        check("left after parity retry", kif.keyboard, 4'b0001);
        send_checked(8'hE0, 0, -1);
        send_checked(8'hF0, 0, -1);
        send_checked(8'h6B, 0, -1);

        // Timeout on a truncated frame
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 0, -1, -1, 5);
        tick(TIMEOUT_CYCLES + 100);
        check("timeout frame_err", fe_cnt - fe0, 1);
        check("timeout code_valid", cv_cnt - cv0, 0);
        send_checked(8'h1C, 0, -1);
        check("A after timeout", kif.keyboard, 4'b0001);

        // Glitch while idle with data low (would look like a start bit)
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        ps2_data = 1'b0;
        tick(4);
        ps2_clk = 1'b0;
        tick(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        tick(4);
        ps2_data = 1'b1;
        tick(40);
        check("idle glitch strobes", (cv_cnt - cv0) + (fe_cnt - fe0), 0);
        send_checked(8'h23, 0, -1);
        check("D after idle glitch", kif.keyboard, 4'b0011);
        send_checked(8'hF0, 0, 4);
        send_checked(8'h23, 0, 7);
        check("D break with glitches", kif.keyboard, 4'b0001);

        // Reset during data bit 5 of the next frame
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h23, 0, -1, 6, 11);
        model_reset();
        check("mid-frame reset strobes", (cv_cnt - cv0) + (fe_cnt - fe0), 0);
        check("mid-frame reset keyboard", kif.keyboard, 4'h0);
        check("mid-frame reset code", kif.code, 8'h00);
        tick(TIMEOUT_CYCLES + 100);
        send_checked(8'h1D, 0, -1);
        check("W after reset", kif.keyboard, 4'b0100);

        // Random byte stream with occasional parity errors and glitches
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            bit bad;
            int g;
            b   = pick_byte();
            bad = ($urandom_range(0, 7) == 0);
            g   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
            send_checked(b, bad, g);
        end

        check("code_valid and frame_err together", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ps2_keypad_rx.md
Name: ps2_keypad_rx

Overview:
- Producer side of the 4-bit `keyboard_in` bus consumed by the Tetris top level.
- Receives PS/2 device-to-host frames from a physical keyboard and decodes make/break scancodes, including the E0 extended prefix.
- Drives a level-held 4-bit key vector: one bit per game action, high while the key is held.
- Also exposes each raw received byte plus an error strobe for debug display on the 7-segment unit.

Parameters:
- FILTER_LEN, 8: consecutive equal samples required before the filtered ps2_clk changes level (glitch reject).
- TIMEOUT_CYCLES, 200000: max idle cycles between ps2_clk falling edges inside a frame (2 ms at 100 MHz) before abort.

Ports:
- FPGA_GlobalClock  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous, idle high.
- ps2_data  in  1  raw PS/2 data, asynchronous, idle high.
- keyboard  out  4  held-key vector; bit0 left, bit1 right, bit2 rotate, bit3 down.
- code  out  8  last valid received byte.
- code_valid  out  1  one-cycle strobe, code updated.
- frame_err  out  1  one-cycle strobe, bad or aborted frame.

Behaviour:
- Reset (rst_n=0 at clock edge): keyboard=0, code=0x00, code_valid=0, frame_err=0. FSM goes to IDLE; ext/brk flags, bit counter, shift register and timeout counter clear; filtered clock is set to 1. Reset mid-frame discards the partial frame with no strobe.
- Input conditioning:
  - Both inputs pass through a 2-FF synchronizer.
  - Synced ps2_clk feeds the filter: the filtered level changes only after FILTER_LEN consecutive samples at the new level.
  - Fall event is a one-cycle pulse when the filtered clock goes 1->0. Data is sampled (synced ps2_data) in the fall-event cycle.
- Frame FSM:
  - IDLE: on fall event with data=0 (start bit), go to RX with bitcnt=0. A fall event with data=1 is ignored.
  - RX: each fall event shifts data in LSB-first. bitcnt 0..7 are data bits, 8 is parity, 9 is stop.
  - RX, on the stop-bit fall event: the frame is good iff parity makes the odd-parity total over data+parity bits, and stop=1.
    - Good: next cycle code=byte, code_valid=1, decoder updates; return to IDLE.
    - Bad: next cycle frame_err=1, no decode, flags unchanged; return to IDLE.
  - RX timeout: the counter resets on each fall event. On reaching TIMEOUT_CYCLES, frame_err pulses the next cycle, FSM goes to IDLE, flags are unchanged.
- Decoder, acts on each good byte in the code_valid cycle:
  - 0xE0: ext=1.
  - 0xF0: brk=1.
  - Other byte: lookup. If mapped, keyboard[bit] = ~brk. Then ext=0 and brk=0.
  - Mapped with ext=1: 0x6B left(0), 0x74 right(1), 0x75 rotate(2), 0x72 down(3).
  - Mapped with ext=0: 0x1C A left(0), 0x23 D right(1), 0x1D W rotate(2), 0x1B S down(3).
  - Unmapped (including 0xE1, 0xAA, 0xFA, and arrow codes without E0): no keyboard change; flags clear.
  - Repeated make (typematic) is idempotent. Bits are independent, so multiple keys may be held simultaneously.
- Latency: stop-bit fall event at cycle N gives code/code_valid/keyboard updated at N+1.
- code_valid and frame_err are never both high in the same cycle.
- Byte values for prefixes are reported on code like any other byte.

Test Plan:
- Left-arrow make/break: frames E0,6B -> keyboard=0001, code_valid twice, code=0x6B. Then E0,F0,6B -> keyboard=0000, three code_valid pulses.
- Simultaneous keys: make 1D (W) then E0,72 -> keyboard=1100. Break F0,1D -> keyboard=1000.
- Parity error: byte 0x6B sent with even parity -> frame_err one cycle, code_valid never high, keyboard and code unchanged.
- Timeout: start bit plus 4 data bits, then idle TIMEOUT_CYCLES -> frame_err one pulse, FSM idle. Next good frame 0x1C -> keyboard[0]=1.
- Glitch reject: ps2_clk low pulse of FILTER_LEN-2 cycles while idle or mid-frame -> no bit sampled; a subsequent valid frame decodes correctly.
- Reset mid-frame: keyboard=0001 held, rst_n low 1 cycle during bit 5 of the next frame -> keyboard=0000, no strobes. The remaining bits of the interrupted frame fall outside a frame context; the next full frame decodes normally.
